uart_tx: RTL and testbench

//   8N1 UART transmitter, the transmit-side counterpart of the UART receiver.

---
 rtl/uart_tx.sv | 161 ++++++++++++++++
 tb/tb_uart_tx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small input FIFO and a fixed baud divisor.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_tx #(
   parameter int CLKS_PER_BIT = 10417,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [7:0]                         in_data,
   input  logic                               in_valid,
   output logic                               in_ready,
   output logic                               tx,
   output logic                               busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int CW = $clog2(FIFO_DEPTH+1);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT-1);
   localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t          state, state_d;
   logic [BW-1:0]   baud_cnt, cnt_d;
   logic [2:0]      bit_idx, idx_d;
   logic [7:0]      byte_q, byte_d;
   logic            tx_q, tx_d;
   logic            bit_end, pop, push, empty;

   logic [7:0]      mem [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;

   assign empty      = (count == '0);
   assign in_ready   = (count != FULL);
   assign push       = in_valid & in_ready;
   assign fifo_count = count;
   assign tx         = tx_q;
   assign busy       = (state != IDLE) | ~empty;

   // Storage needs no reset: zeroed pointers and count make stale entries unreachable.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         byte_q   <= '0;
         tx_q     <= 1'b1;
      end else begin
         state    <= state_d;
         baud_cnt <= cnt_d;
         bit_idx  <= idx_d;
         byte_q   <= byte_d;
         tx_q     <= tx_d;
      end
   end

   assign bit_end = (baud_cnt == BAUD_LAST);

   always_comb begin
      state_d = state;
      cnt_d   = baud_cnt;
      idx_d   = bit_idx;
      byte_d  = byte_q;
      tx_d    = tx_q;
      pop     = 1'b0;
      if (state != IDLE) cnt_d = bit_end ? '0 : baud_cnt + 1'b1;
      case (state)
         IDLE: begin
            cnt_d = '0;
            tx_d  = 1'b1;
            if (!empty) begin
               pop     = 1'b1;
               byte_d  = mem[rd_ptr];
               state_d = START;
               tx_d    = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_d = DATA;
               idx_d   = '0;
               tx_d    = byte_q[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
                  tx_d    = ^byte_q;
`else
                  state_d = STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  idx_d = bit_idx + 3'd1;
                  tx_d  = byte_q[idx_d];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               state_d = STOP;
               tx_d    = 1'b1;
            end
         end
`endif
         STOP: begin
            // Chain straight into the next start bit so back-to-back frames are contiguous.
            if (bit_end) begin
               if (!empty) begin
                  pop     = 1'b1;
                  byte_d  = mem[rd_ptr];
                  state_d = START;
                  tx_d    = 1'b0;
               end else begin
                  state_d = IDLE;
                  tx_d    = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// Randomized scoreboard bench for uart_tx: a frame-level model predicts pins,
// and a serial decoder monitor matches each frame on tx against accepted bytes.
module tb_uart_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif
   localparam int FRAME = NB * CPB;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] in_data = '0;
   logic       in_valid = 1'b0;
   logic       in_ready, tx, busy;
   logic [2:0] fifo_count;

   int checks = 0;
   int errors = 0;

   // behavioural model: bytes waiting, byte in flight, cycles of frame left
   logic [7:0]    mq[$];
   logic [7:0]    exp_q[$];
   logic [NB-1:0] m_frame = '1;
   int            m_left = 0;

   uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [NB-1:0] frame_bits(input logic [7:0] b);
      logic [NB-1:0] f;
      f = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
      f[9] = ($countones(b) % 2) == 1;
`endif
      return f;
   endfunction

   // one clock edge of the model, applied right after the DUT edge
   task automatic model_edge();
      int  sz;
      bit  pop_now;
      sz = mq.size();
      pop_now = (sz > 0) && (m_left <= 1);
      if (pop_now) begin
         m_frame = frame_bits(mq.pop_front());
         m_left  = FRAME;
      end else if (m_left > 0) begin
         m_left--;
      end
      if (in_valid && sz < DEPTH) begin
         mq.push_back(in_data);
         exp_q.push_back(in_data);
      end
   endtask

   task automatic step(input logic v, input logic [7:0] d);
      in_valid = v;
      in_data  = d;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset(input string tag);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      #1;
      chk({tag, "_tx"}, tx, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_ready"}, in_ready, 1);
      chk({tag, "_count"}, fifo_count, 0);
      mq.delete();
      exp_q.delete();
      m_left  = 0;
      m_frame = '1;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // cycle checker against the model
   always @(negedge clk) begin
      chk("pin_tx", tx, (m_left > 0) ? m_frame[(FRAME - m_left) / CPB] : 1'b1);
      chk("pin_busy", busy, (m_left > 0) || (mq.size() > 0));
      chk("pin_ready", in_ready, mq.size() != DEPTH);
      chk("pin_count", fifo_count, mq.size());
   end

   // serial decoder monitor: pops the scoreboard when a start bit appears
   logic [63:0]   got, want;
   logic [NB-1:0] fb;
   bit            aborted;
   int            n;
   always begin
      @(negedge clk);
      if (rst_n && tx === 1'b0) begin
         got = '0;
         want = '0;
         aborted = 0;
         got[0] = tx;
         n = 1;
         while (n < FRAME && !aborted) begin
            @(negedge clk);
            if (!rst_n) aborted = 1;
            else begin
               got[n] = tx;
               n++;
            end
         end
         if (!aborted) begin
            if (exp_q.size() == 0) begin
               chk("sb_unexpected_frame", got, 64'h0);
            end else begin
               fb = frame_bits(exp_q.pop_front());
               for (int i = 0; i < FRAME; i++) want[i] = fb[i / CPB];
               chk("sb_frame", got, want);
            end
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // single byte: start at N+1, idle at N+41
      step(1, 8'h55);
      step(0, 8'h00);
      chk("single_start", tx, 0);
      repeat (39) step(0, 8'h00);
      chk("single_busy_mid", busy, 1);
      step(0, 8'h00);
      chk("single_busy_done", busy, 0);
      repeat (5) step(0, 8'h00);

      // back-to-back frames
      step(1, 8'hA5);
      step(1, 8'h3C);
      repeat (90) step(0, 8'h00);

      // full FIFO: 0x06 must be dropped
      for (int i = 1; i <= 6; i++) step(1, 8'(i));
      step(0, 8'h00);
      chk("full_count", fifo_count, 4);
      chk("full_ready", in_ready, 0);
      repeat (220) step(0, 8'h00);

      // parity-relevant bytes
      step(1, 8'h07);
      step(1, 8'h03);
      repeat (100) step(0, 8'h00);

      // reset with bytes queued
      for (int i = 0; i < 3; i++) step(1, 8'($urandom));
      repeat (10) step(0, 8'h00);
      do_reset("rst_queued");
      repeat (5) step(0, 8'h00);

      // reset during data bit 3 of 0xFF
      step(1, 8'hFF);
      repeat (18) step(0, 8'h00);
      chk("rst_mid_before", tx, 1);
      do_reset("rst_midframe");
      repeat (60) step(0, 8'h00);
      chk("rst_mid_after_count", fifo_count, 0);
      chk("rst_mid_after_busy", busy, 0);

      // random traffic: sparse, then dense enough to overflow
      for (int i = 0; i < 1500; i++) step($urandom_range(0, 49) == 0, 8'($urandom));
      for (int i = 0; i < 1500; i++) step($urandom_range(0, 1) == 0, 8'($urandom));

      // drain with a bound
      for (int i = 0; i < 1000 && (m_left > 0 || mq.size() > 0); i++) step(0, 8'h00);
      repeat (5) step(0, 8'h00);
      chk("drain_model_idle", (m_left > 0 || mq.size() > 0), 0);
      chk("drain_busy", busy, 0);
      chk("drain_scoreboard_empty", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
